// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared encodings for the fetch PC sequencer
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      PCSEL_SEQ  = 2'b00,
      PCSEL_JUMP = 2'b01,
      PCSEL_BALZ = 2'b10,
      PCSEL_BREL = 2'b11
   } pc_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_FETCH    = 2'b01,
      ST_HOLD     = 2'b10,
      ST_REDIRECT = 2'b11
   } state_e;

   localparam logic [31:0] INSTR_STEP  = 32'd4;
   localparam int unsigned FLUSH_CNT_W = 3;

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - combinational next-PC target computation
module pc_target_calc
   import pc_sequencer_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [1:0]  pc_sel,
   input  logic [25:0] jaddr,
   input  logic [15:0] imm,
   output logic [31:0] pc_plus4,
   output logic [31:0] target
);

   logic [31:0] jump_target;
   logic [31:0] branch_target;

   assign pc_plus4      = pc + INSTR_STEP;
   assign jump_target   = {pc_plus4[31:28], jaddr, 2'b00};
   // word offset is sign-extended then scaled to bytes; the add wraps mod 2^32
   assign branch_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};

   always_comb begin
      target = pc_plus4;
      case (pc_sel_e'(pc_sel))
         PCSEL_SEQ:  target = pc_plus4;
         PCSEL_JUMP: target = jump_target;
         PCSEL_BALZ: target = jump_target;
         PCSEL_BREL: target = branch_target;
         default:    target = pc_plus4;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with redirect flush and stall hold
// Optional link-register write on balz is enabled by defining PC_SEQ_LINK_EN.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  pc_sel,
   input  logic        sel_valid,
   input  logic [25:0] jaddr,
   input  logic [15:0] imm,
   input  logic        stall,
   input  logic        imem_ack,
   output logic        imem_req,
   output logic [31:0] pc,
   output logic        flush,
   output logic        link_we,
   output logic [31:0] link_data
);

   localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

   state_e                 state;
   logic [FLUSH_CNT_W-1:0] flush_cnt;
   logic [31:0]            pc_plus4;
   logic [31:0]            target;
   logic                   redirect;
   logic                   advance;

   pc_target_calc u_target_calc (
      .pc       (pc),
      .pc_sel   (pc_sel),
      .jaddr    (jaddr),
      .imm      (imm),
      .pc_plus4 (pc_plus4),
      .target   (target)
   );

   assign redirect = sel_valid && (pc_sel != PCSEL_SEQ);
   assign advance  = (state == ST_FETCH) && imem_ack && !stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         pc        <= RESET_PC;
         imem_req  <= 1'b0;
         flush     <= 1'b0;
         flush_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state    <= ST_FETCH;
               imem_req <= 1'b1;
            end
            ST_FETCH: begin
               if (imem_ack && stall) begin
                  state    <= ST_HOLD;
                  imem_req <= 1'b0;
               end else if (advance) begin
                  if (redirect) begin
                     pc        <= target;
                     state     <= ST_REDIRECT;
                     imem_req  <= 1'b0;
                     flush     <= 1'b1;
                     flush_cnt <= FLUSH_LOAD;
                  end else begin
                     pc <= pc_plus4;
                  end
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  state    <= ST_FETCH;
                  imem_req <= 1'b1;
               end
            end
            ST_REDIRECT: begin
               // the flush window is fixed length; stall only decides where we land after it
               if (flush_cnt == '0) begin
                  flush    <= 1'b0;
                  state    <= stall ? ST_HOLD : ST_FETCH;
                  imem_req <= !stall;
               end else begin
                  flush_cnt <= flush_cnt - 1'b1;
               end
            end
            default: begin
               state    <= ST_IDLE;
               imem_req <= 1'b0;
               flush    <= 1'b0;
            end
         endcase
      end
   end

`ifdef PC_SEQ_LINK_EN
   logic balz_adv;

   assign balz_adv = advance && sel_valid && (pc_sel == PCSEL_BALZ);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         link_we   <= 1'b0;
         link_data <= '0;
      end else begin
         link_we <= balz_adv;
         if (balz_adv) begin
            link_data <= pc_plus4;
         end
      end
   end
`else
   assign link_we   = 1'b0;
   assign link_data = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

   logic        clk;
   logic        rst_n;
   logic [1:0]  pc_sel;
   logic        sel_valid;
   logic [25:0] jaddr;
   logic [15:0] imm;
   logic        stall;
   logic        imem_ack;
   logic        imem_req;
   logic [31:0] pc;
   logic        flush;
   logic        link_we;
   logic [31:0] link_data;

   int checks;
   int errors;

   typedef struct {
      logic        sv;
      logic [1:0]  sel;
      logic [25:0] ja;
      logic [15:0] im;
      logic [31:0] exp_pc;
      logic        redir;
      logic        balz;
      logic [31:0] exp_link;
   } vec_t;

   localparam int NVEC = 17;
   vec_t        tbl[NVEC];
   logic [31:0] exp_q[$];

   pc_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pc_sel    (pc_sel),
      .sel_valid (sel_valid),
      .jaddr     (jaddr),
      .imm       (imm),
      .stall     (stall),
      .imem_ack  (imem_ack),
      .imem_req  (imem_req),
      .pc        (pc),
      .flush     (flush),
      .link_we   (link_we),
      .link_data (link_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_link(input string name, input logic exp_we, input logic [31:0] exp_data);
`ifdef PC_SEQ_LINK_EN
      chk({name, "_link_we"}, 32'(link_we), 32'(exp_we));
      if (exp_we) chk({name, "_link_data"}, link_data, exp_data);
`else
      chk({name, "_link_we"}, 32'(link_we), 32'h0);
      chk({name, "_link_data"}, link_data, 32'h0);
      if (exp_we && exp_data == 32'hFFFF_FFFF) chk(name, 32'h0, 32'h1);
`endif
   endtask

   task automatic idle_inputs();
      sel_valid = 1'b0;
      pc_sel    = 2'b00;
      jaddr     = '0;
      imm       = '0;
      imem_ack  = 1'b0;
      stall     = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      idle_inputs();

      tbl[0]  = '{1'b0, 2'b00, 26'h0,       16'h0000, 32'h0000_0004, 1'b0, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, 2'b00, 26'h0,       16'h0000, 32'h0000_0008, 1'b0, 1'b0, 32'h0};
      tbl[2]  = '{1'b0, 2'b00, 26'h0,       16'h0000, 32'h0000_000C, 1'b0, 1'b0, 32'h0};
      tbl[3]  = '{1'b0, 2'b01, 26'h3FFFFFF, 16'hFFFF, 32'h0000_0010, 1'b0, 1'b0, 32'h0};
      tbl[4]  = '{1'b1, 2'b01, 26'h0000100, 16'h0000, 32'h0000_0400, 1'b1, 1'b0, 32'h0};
      tbl[5]  = '{1'b1, 2'b01, 26'h0000010, 16'h0000, 32'h0000_0040, 1'b1, 1'b0, 32'h0};
      tbl[6]  = '{1'b1, 2'b11, 26'h0,       16'hFFFE, 32'h0000_003C, 1'b1, 1'b0, 32'h0};
      tbl[7]  = '{1'b1, 2'b01, 26'h0000010, 16'h0000, 32'h0000_0040, 1'b1, 1'b0, 32'h0};
      tbl[8]  = '{1'b1, 2'b11, 26'h0,       16'h0003, 32'h0000_0050, 1'b1, 1'b0, 32'h0};
      tbl[9]  = '{1'b1, 2'b01, 26'h0000020, 16'h0000, 32'h0000_0080, 1'b1, 1'b0, 32'h0};
      tbl[10] = '{1'b1, 2'b10, 26'h0000040, 16'h0000, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0084};
      tbl[11] = '{1'b1, 2'b11, 26'h0,       16'h8000, 32'hFFFE_0104, 1'b1, 1'b0, 32'h0};
      tbl[12] = '{1'b1, 2'b11, 26'h0,       16'h7FFF, 32'h0000_0104, 1'b1, 1'b0, 32'h0};
      tbl[13] = '{1'b1, 2'b11, 26'h0,       16'hFFBD, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0};
      tbl[14] = '{1'b0, 2'b00, 26'h0,       16'h0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0};
      tbl[15] = '{1'b1, 2'b11, 26'h0,       16'h8000, 32'hFFFE_0004, 1'b1, 1'b0, 32'h0};
      tbl[16] = '{1'b1, 2'b01, 26'h0000100, 16'h0000, 32'hF000_0400, 1'b1, 1'b0, 32'h0};

      // reset state
      step();
      step();
      chk("rst_pc", pc, 32'h0);
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_flush", 32'(flush), 32'h0);
      check_link("rst", 1'b0, 32'h0);

      rst_n = 1'b1;
      #1;
      chk("idle_req", 32'(imem_req), 32'h0);
      @(negedge clk);
      chk("fetch_req", 32'(imem_req), 32'h1);
      chk("fetch_pc", pc, 32'h0);

      for (int i = 0; i < NVEC; i++) begin
         int wait_cyc;
         logic [31:0] exp_pc;
         wait_cyc = 0;
         while (imem_req !== 1'b1 && wait_cyc < 20) begin
            step();
            wait_cyc++;
         end
         if (imem_req !== 1'b1) chk($sformatf("vec%0d_wait_req", i), 32'(imem_req), 32'h1);
         sel_valid = tbl[i].sv;
         pc_sel    = tbl[i].sel;
         jaddr     = tbl[i].ja;
         imm       = tbl[i].im;
         imem_ack  = 1'b1;
         exp_q.push_back(tbl[i].exp_pc);
         step();
         idle_inputs();
         exp_pc = exp_q.pop_front();
         chk($sformatf("vec%0d_pc", i), pc, exp_pc);
         chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(tbl[i].redir));
         chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(!tbl[i].redir));
         check_link($sformatf("vec%0d", i), tbl[i].balz, tbl[i].exp_link);
         if (tbl[i].redir) begin
            step();
            chk($sformatf("vec%0d_flush2", i), 32'(flush), 32'h1);
            chk($sformatf("vec%0d_req2", i), 32'(imem_req), 32'h0);
            check_link($sformatf("vec%0d_pulse_end", i), 1'b0, 32'h0);
            step();
            chk($sformatf("vec%0d_flush3", i), 32'(flush), 32'h0);
            chk($sformatf("vec%0d_req3", i), 32'(imem_req), 32'h1);
            chk($sformatf("vec%0d_pc_hold", i), pc, exp_pc);
         end
      end
      chk("sb_empty", 32'(exp_q.size()), 32'h0);

      // reset asserted in the middle of a redirect
      sel_valid = 1'b1;
      pc_sel    = 2'b01;
      jaddr     = 26'h0000008;
      imem_ack  = 1'b1;
      step();
      idle_inputs();
      chk("mid_redir_flush", 32'(flush), 32'h1);
      chk("mid_redir_pc", pc, 32'hF000_0020);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_flush", 32'(flush), 32'h0);
      chk("async_pc", pc, 32'h0);
      chk("async_req", 32'(imem_req), 32'h0);
      step();
      chk("rst_hold_flush", 32'(flush), 32'h0);
      rst_n = 1'b1;
      #1;
      chk("rearm_idle_req", 32'(imem_req), 32'h0);
      @(negedge clk);
      chk("rearm_fetch_req", 32'(imem_req), 32'h1);
      chk("rearm_pc", pc, 32'h0);
      chk("rearm_flush", 32'(flush), 32'h0);

      // stall with ack at 0x20
      imem_ack = 1'b1;
      for (int k = 0; k < 8; k++) step();
      chk("pre_stall_pc", pc, 32'h20);
      stall = 1'b1;
      step();
      chk("hold_pc", pc, 32'h20);
      chk("hold_req", 32'(imem_req), 32'h0);
      step();
      step();
      chk("hold_pc2", pc, 32'h20);
      chk("hold_req2", 32'(imem_req), 32'h0);
      stall = 1'b0;
      step();
      chk("resume_req", 32'(imem_req), 32'h1);
      chk("resume_pc", pc, 32'h20);
      step();
      chk("resume_adv_pc", pc, 32'h24);

      // no ack: wait indefinitely
      imem_ack = 1'b0;
      step();
      step();
      step();
      chk("noack_pc", pc, 32'h24);
      chk("noack_req", 32'(imem_req), 32'h1);

      // stall and junk selects during redirect
      sel_valid = 1'b1;
      pc_sel    = 2'b01;
      jaddr     = 26'h0000040;
      imem_ack  = 1'b1;
      step();
      jaddr = 26'h0000003;
      stall = 1'b1;
      chk("sr_flush1", 32'(flush), 32'h1);
      chk("sr_pc", pc, 32'h100);
      step();
      chk("sr_flush2", 32'(flush), 32'h1);
      step();
      chk("sr_flush_end", 32'(flush), 32'h0);
      chk("sr_hold_req", 32'(imem_req), 32'h0);
      idle_inputs();
      stall = 1'b1;
      step();
      chk("sr_hold_flush", 32'(flush), 32'h0);
      chk("sr_hold_pc", pc, 32'h100);
      stall = 1'b0;
      step();
      chk("sr_resume_req", 32'(imem_req), 32'h1);
      chk("sr_resume_pc", pc, 32'h100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter FLUSH_CYCLES, default 2, cycles flush is held after a redirect (legal 1..7).
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pc_sel  input  2  next-PC select: 00 ordinary, 01 jump (26-bit), 10 balz (26-bit), 11 branch PC-relative.
REQ-006 sel_valid  input  1  pc_sel/jaddr/imm valid this cycle.
REQ-007 jaddr  input  26  jump/balz target field.
REQ-008 imm  input  16  branch offset in words, signed.
REQ-009 stall  input  1  downstream hazard; blocks PC advance.
REQ-010 imem_ack  input  1  instruction memory accepted current fetch.
REQ-011 imem_req  output  1  fetch request at pc.
REQ-012 pc  output  32  current fetch address.
REQ-013 flush  output  1  squash younger in-flight instructions.
REQ-014 link_we  output  1  write link register ($31).
REQ-015 link_data  output  32  return address (pc+4 of the balz).

Function
REQ-016 States SHALL be IDLE, FETCH, HOLD, REDIRECT; encoding 2-bit.
REQ-017 IDLE SHALL last exactly one cycle after rst_n deasserts, then go to FETCH; imem_req=0 in IDLE.
REQ-018 FETCH SHALL drive imem_req=1; advance occurs on a cycle with imem_ack=1 and stall=0.
REQ-019 On advance with sel_valid=0 or pc_sel=00, pc SHALL become pc+4 (mod 2^32) at the next edge; state stays FETCH.
REQ-020 On advance with sel_valid=1 and pc_sel=01 or 10, pc SHALL become {pc_plus4[31:28], jaddr, 2'b00}.
REQ-021 On advance with sel_valid=1 and pc_sel=11, pc SHALL become pc_plus4 + (sign-extended imm << 2), wrapping mod 2^32.
REQ-022 Any redirect (pc_sel!=00 with sel_valid) SHALL go to REDIRECT, with flush=1 from the next cycle for exactly FLUSH_CYCLES cycles.
REQ-023 REDIRECT SHALL hold imem_req=0, ignore sel_valid, then return to FETCH.
REQ-024 FETCH with imem_ack=1 and stall=1 SHALL keep pc unchanged and go to HOLD; stall has priority over ack.
REQ-025 HOLD SHALL drive imem_req=0, keep pc, return to FETCH on the first cycle stall=0.
REQ-026 FETCH with imem_ack=0 SHALL keep pc and imem_req=1 (wait indefinitely).
REQ-027 Stall asserted during REDIRECT SHALL NOT extend flush; after REDIRECT the FSM enters HOLD if stall=1, else FETCH.
REQ-028 pc_sel and sel_valid SHALL be sampled only on an advance cycle.

Reset
REQ-029 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, pc=RESET_PC, imem_req=0, flush=0, link_we=0, link_data=0, flush counter=0.
REQ-030 Reset asserted mid-REDIRECT or mid-HOLD SHALL abandon the operation; no redirect is replayed.

Configuration
REQ-031 Macro PC_SEQ_LINK_EN: defined -> a balz advance SHALL pulse link_we=1 for one cycle (the cycle after the advance) with link_data=pc_plus4 of the balz.
REQ-032 Without PC_SEQ_LINK_EN, link_we and link_data SHALL be constant 0; balz redirects identically to jump.

Structure
REQ-033 Shared package SHALL hold pc_sel encodings (PCSEL_SEQ/JUMP/BALZ/BREL), the state encoding and the 4-byte instruction step.
REQ-034 One sub-module, pc_target_calc (combinational: pc, pc_sel, jaddr, imm -> pc_plus4, target), SHALL compute targets.

Verification
REQ-035 Reset release, imem_ack=1 held, stall=0, sel_valid=0 -> pc 0x0, then 0x4, 0x8, 0xC on successive advances; imem_req=0 for one IDLE cycle.
REQ-036 pc=0x1000_0010, pc_sel=01, jaddr=26'h0000100 -> pc=0x1000_0400, flush high exactly 2 cycles, imem_req low during them.
REQ-037 pc=0x0000_0040, pc_sel=11, imm=16'hFFFE -> pc=0x0000_003C; imm=16'h0003 -> pc=0x0000_0050.
REQ-038 imem_ack=1 and stall=1 same cycle at pc=0x20 -> pc stays 0x20, HOLD until stall=0, then fetch resumes at 0x20.
REQ-039 PC_SEQ_LINK_EN defined, balz at pc=0x0000_0080, jaddr=26'h40 -> link_we one-cycle pulse, link_data=0x0000_0084, pc=0x0000_0100.
REQ-040 rst_n pulsed low during REDIRECT -> flush drops asynchronously, pc=RESET_PC, IDLE then FETCH.
